// File: rtl/tree_pkg.sv
// Shared constants and write-FSM encoding for the decision-tree feature feeder.
package tree_pkg;

    // Default geometry: feature width matches the tree node DATA field.
    localparam int unsigned DEF_DATA_W = 8;
    localparam int unsigned DEF_NFEAT  = 8;
    localparam int unsigned DEF_IDX_W  = 3;

    // Write side: FILL stores bytes, DROP discards the tail of an overlength sample.
    typedef enum logic [0:0] {
        FILL = 1'b0,
        DROP = 1'b1
    } wr_state_e;

endpackage

// File: rtl/fbuf_bank.sv
// One feature bank: single write port, registered read port (1-cycle latency).
module fbuf_bank #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned ADDR_W = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Storage array; contents need no reset since reads are gated by the sample count.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Registered read so the walker sees data one cycle after presenting an index.
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata <= '0;
        end else begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/feature_pingpong_buf.sv
// Ping-pong feature buffer feeding the decision-tree walker.
// One bank fills from the byte stream while the walker reads the other.
// Optional: define FEAT_OVF_ERR_EN to enable the sticky overlength flag ovf_err_o.
module feature_pingpong_buf
    import tree_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned NFEAT  = DEF_NFEAT,
    parameter int unsigned IDX_W  = DEF_IDX_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid_i,
    input  logic [DATA_W-1:0] in_data_i,
    input  logic              in_last_i,
    output logic              in_ready_o,
    input  logic [IDX_W-1:0]  feat_idx_i,
    output logic [DATA_W-1:0] feat_data_o,
    output logic              sample_valid_o,
    output logic [IDX_W:0]    feat_cnt_o,
    input  logic              sample_done_i,
    output logic              ovf_err_o
);

    localparam logic [IDX_W-1:0] PTR_MAX = IDX_W'(NFEAT - 1);

    wr_state_e         state_q;
    wr_state_e         state_d;
    logic [1:0]        full_q;
    logic [IDX_W:0]    cnt_q [2];
    logic              wr_bank_q;
    logic              rd_bank_q;
    logic [IDX_W-1:0]  wr_ptr_q;

    logic              accept;
    logic              wr_en;
    logic              complete;
    logic              release_rd;

    logic              rd_sel_q;
    logic              rd_hit_q;
    logic [DATA_W-1:0] rdata0;
    logic [DATA_W-1:0] rdata1;

    // Upstream may push while the write bank is free; in DROP bytes are always sunk.
    assign in_ready_o = !full_q[wr_bank_q] || (state_q == DROP);
    assign accept     = in_valid_i && in_ready_o;
    assign release_rd = sample_done_i && full_q[rd_bank_q];

    // Write FSM next state and per-byte control.
    always_comb begin
        state_d  = state_q;
        wr_en    = 1'b0;
        complete = 1'b0;
        unique case (state_q)
            FILL: begin
                if (accept) begin
                    wr_en = 1'b1;
                    if (in_last_i || (wr_ptr_q == PTR_MAX)) begin
                        complete = 1'b1;
                    end
                    if (!in_last_i && (wr_ptr_q == PTR_MAX)) begin
                        state_d = DROP;
                    end
                end
            end
            DROP: begin
                if (accept && in_last_i) begin
                    state_d = FILL;
                end
            end
            default: state_d = FILL;
        endcase
    end

    // Write FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FILL;
        end else begin
            state_q <= state_d;
        end
    end

    // Write pointer and write-bank select; a completed sample hands over to the other bank.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q  <= '0;
            wr_bank_q <= 1'b0;
        end else if (complete) begin
            wr_ptr_q  <= '0;
            wr_bank_q <= !wr_bank_q;
        end else if (wr_en) begin
            wr_ptr_q  <= wr_ptr_q + IDX_W'(1);
        end
    end

    // Per-bank full/count flags; completion and release always target different banks.
    always_ff @(posedge clk) begin
        if (reset) begin
            full_q   <= '0;
            cnt_q[0] <= '0;
            cnt_q[1] <= '0;
        end else begin
            for (int unsigned b = 0; b < 2; b++) begin
                if (complete && (wr_bank_q == b[0])) begin
                    full_q[b] <= 1'b1;
                    cnt_q[b]  <= {1'b0, wr_ptr_q} + (IDX_W + 1)'(1);
                end else if (release_rd && (rd_bank_q == b[0])) begin
                    full_q[b] <= 1'b0;
                end
            end
        end
    end

    // Read-bank select advances when the walker releases a valid sample.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_bank_q <= 1'b0;
        end else if (release_rd) begin
            rd_bank_q <= !rd_bank_q;
        end
    end

    // Bank select and range check are registered alongside the bank read data
    // so that the output mux lines up with the 1-cycle read latency.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_sel_q <= 1'b0;
            rd_hit_q <= 1'b0;
        end else begin
            rd_sel_q <= rd_bank_q;
            rd_hit_q <= ({1'b0, feat_idx_i} < cnt_q[rd_bank_q]);
        end
    end

    fbuf_bank #(
        .DATA_W (DATA_W),
        .DEPTH  (NFEAT),
        .ADDR_W (IDX_W)
    ) u_bank0 (
        .clk   (clk),
        .reset (reset),
        .we    (wr_en && !wr_bank_q),
        .waddr (wr_ptr_q),
        .wdata (in_data_i),
        .raddr (feat_idx_i),
        .rdata (rdata0)
    );

    fbuf_bank #(
        .DATA_W (DATA_W),
        .DEPTH  (NFEAT),
        .ADDR_W (IDX_W)
    ) u_bank1 (
        .clk   (clk),
        .reset (reset),
        .we    (wr_en && wr_bank_q),
        .waddr (wr_ptr_q),
        .wdata (in_data_i),
        .raddr (feat_idx_i),
        .rdata (rdata1)
    );

    assign feat_data_o    = rd_hit_q ? (rd_sel_q ? rdata1 : rdata0) : '0;
    assign sample_valid_o = full_q[rd_bank_q];
    assign feat_cnt_o     = full_q[rd_bank_q] ? cnt_q[rd_bank_q] : '0;

`ifdef FEAT_OVF_ERR_EN
    logic ovf_q;

    // Sticky overlength flag: set on every FILL->DROP transition, cleared only by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_q <= 1'b0;
        end else if ((state_q == FILL) && (state_d == DROP)) begin
            ovf_q <= 1'b1;
        end
    end

    assign ovf_err_o = ovf_q;
`else
    assign ovf_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_feature_pingpong_buf.sv
// Scoreboard bench for feature_pingpong_buf: random samples in, walker reads out.
module tb_feature_pingpong_buf;

    localparam int unsigned NF = 8;
`ifdef FEAT_OVF_ERR_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid_i = 1'b0;
    logic [7:0] in_data_i = '0;
    logic       in_last_i = 1'b0;
    logic       in_ready_o;
    logic [2:0] feat_idx_i = '0;
    logic [7:0] feat_data_o;
    logic       sample_valid_o;
    logic [3:0] feat_cnt_o;
    logic       sample_done_i = 1'b0;
    logic       ovf_err_o;

    feature_pingpong_buf dut (
        .clk            (clk),
        .reset          (reset),
        .in_valid_i     (in_valid_i),
        .in_data_i      (in_data_i),
        .in_last_i      (in_last_i),
        .in_ready_o     (in_ready_o),
        .feat_idx_i     (feat_idx_i),
        .feat_data_o    (feat_data_o),
        .sample_valid_o (sample_valid_o),
        .feat_cnt_o     (feat_cnt_o),
        .sample_done_i  (sample_done_i),
        .ovf_err_o      (ovf_err_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  b [NF];
        int unsigned cnt;
    } samp_t;

    samp_t       exp_q [$];
    logic [7:0]  cur [$];
    int unsigned occ = 0;
    bit          dropping = 1'b0;
    bit          ovf_exp = 1'b0;
    bit          reader_en = 1'b0;
    bit          reader_busy = 1'b0;
    int unsigned checks = 0;
    int unsigned errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: samples are sequences of bytes cut at 'last' or at NF bytes;
    // bytes after a cut are discarded until the next 'last'. At most two samples are held.
    always @(negedge clk) begin
        if (reset) begin
            cur.delete();
            exp_q.delete();
            occ      = 0;
            dropping = 1'b0;
            ovf_exp  = 1'b0;
        end else begin
            chk("in_ready", {31'b0, in_ready_o}, {31'b0, dropping || (occ < 2)});
            chk("sample_valid", {31'b0, sample_valid_o}, {31'b0, occ > 0});
            chk("ovf_err", {31'b0, ovf_err_o}, {31'b0, ovf_exp && OVF_EN});
            if (sample_done_i && occ > 0) occ--;
            if (in_valid_i && in_ready_o) begin
                if (dropping) begin
                    if (in_last_i) dropping = 1'b0;
                end else begin
                    cur.push_back(in_data_i);
                    if (in_last_i || cur.size() == NF) begin
                        samp_t s;
                        for (int i = 0; i < NF; i++) s.b[i] = (i < cur.size()) ? cur[i] : 8'h00;
                        s.cnt = cur.size();
                        exp_q.push_back(s);
                        occ++;
                        if (!in_last_i) begin
                            dropping = 1'b1;
                            ovf_exp  = 1'b1;
                        end
                        cur.delete();
                    end
                end
            end
        end
    end

    // Walker monitor: pops the expected sample whenever the DUT presents one.
    initial begin
        forever begin
            @(posedge clk); #1;
            if (reader_en && !reset) begin
                if (sample_valid_o) begin
                    samp_t s;
                    reader_busy = 1'b1;
                    if (exp_q.size() == 0) begin
                        errors++;
                        checks++;
                        $display("FAIL scoreboard: DUT presented sample, none expected at %0t", $time);
                        s.cnt = 0;
                        for (int i = 0; i < NF; i++) s.b[i] = 8'h00;
                    end else begin
                        s = exp_q.pop_front();
                    end
                    chk("feat_cnt", {28'b0, feat_cnt_o}, s.cnt);
                    for (int i = 0; i < NF; i++) begin
                        feat_idx_i = 3'(i);
                        @(posedge clk); @(negedge clk);
                        chk($sformatf("feat_data[%0d]", i), {24'b0, feat_data_o},
                            (i < s.cnt) ? {24'b0, s.b[i]} : 32'h0);
                        @(posedge clk); #1;
                    end
                    repeat ($urandom_range(0, 30)) begin
                        @(posedge clk); #1;
                    end
                    sample_done_i = 1'b1;
                    @(posedge clk); #1;
                    sample_done_i = 1'b0;
                    reader_busy = 1'b0;
                end else if ($urandom_range(0, 7) == 0) begin
                    // release request with nothing valid must be ignored
                    sample_done_i = 1'b1;
                    @(posedge clk); #1;
                    sample_done_i = 1'b0;
                end
            end
        end
    end

    // Drive one byte (called just after a rising edge) and hold it until accepted.
    task automatic send_byte(input logic [7:0] d, input logic last);
        int unsigned n = 0;
        in_valid_i = 1'b1;
        in_data_i  = d;
        in_last_i  = last;
        forever begin
            @(negedge clk);
            if (in_ready_o) break;
            n++;
            if (n > 2000) begin
                checks++;
                errors++;
                $display("FAIL accept_timeout: in_ready stuck 0, expected 1 within 2000 cycles");
                break;
            end
        end
        @(posedge clk); #1;
        in_valid_i = 1'b0;
        in_last_i  = 1'b0;
        repeat ($urandom_range(0, 2)) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic send_sample(input int unsigned len);
        for (int unsigned k = 0; k < len; k++)
            send_byte(8'($urandom), k == len - 1);
    endtask

    task automatic drain();
        int unsigned n = 0;
        while ((occ != 0 || exp_q.size() != 0 || reader_busy) && n < 20000) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (n >= 20000) begin
            errors++;
            $display("FAIL drain_timeout: %0d samples still held, expected 0", occ);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_in_ready"}, {31'b0, in_ready_o}, 32'd1);
        chk({tag, "_sample_valid"}, {31'b0, sample_valid_o}, 32'd0);
        chk({tag, "_feat_data"}, {24'b0, feat_data_o}, 32'd0);
        chk({tag, "_feat_cnt"}, {28'b0, feat_cnt_o}, 32'd0);
        chk({tag, "_ovf_err"}, {31'b0, ovf_err_o}, 32'd0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk); #1;

        reader_en = 1'b1;
        // directed first sample: 0x10,0x20,0x30
        send_byte(8'h10, 1'b0);
        send_byte(8'h20, 1'b0);
        send_byte(8'h30, 1'b1);
        // exactly NFEAT with last, then overlength without last until byte 10
        send_sample(8);
        send_sample(10);
        for (int s = 0; s < 40; s++) send_sample($urandom_range(1, 11));
        drain();

        // reset with one full bank and a partial sample in flight
        reader_en = 1'b0;
        @(posedge clk); #1;
        send_sample(3);
        send_byte(8'hA5, 1'b0);
        send_byte(8'h5A, 1'b0);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check_reset_outputs("midreset");
        @(posedge clk); #1;
        reader_en = 1'b1;
        send_sample(5);
        send_sample(2);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Absolute watchdog so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

endmodule
